uart_rx_sampler: RTL and testbench

//  Oversampling UART receiver feeding the RS232 MMIO block's RX FIFO.

---
 rtl/uart_rx_sampler.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling 8N1 UART receiver.
// The raw RXD pin is synchronised first. Each bit is decided by a 3-sample
// majority vote at its centre. A received byte sits in a one-deep holding
// register until the consumer acknowledges it with a VALID/READ handshake.
// A framing error or an overrun is reported as a single-cycle pulse.
module uart_rx_sampler #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       ACLK,
  input  logic       RESET_N,
  input  logic       RXD,
  input  logic       RX_DATA_READ,
  output logic [7:0] RX_DATA,
  output logic       RX_DATA_VALID,
  output logic       RX_FRAME_ERR,
  output logic       RX_OVERRUN
);

  // Clocks per sample tick, rounded to the nearest integer.
  localparam int DIV   = (CLOCK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0]  SC_S0    = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_S1    = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0]  SC_S2    = SC_W'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       sync_reg;
  logic             rxs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [SC_W-1:0]  sc;
  logic             samp0;
  logic             samp1;
  logic             maj;
  logic             at_centre;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             clr_timing;
  logic             shift_en;
  logic             deliver;
  logic             frame_err_set;

  // Two-flop synchroniser chain; stage 0 captures the pin, the last stage is rxs.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    // Synchroniser stage gi; resets to the idle (high) line level.
    always_ff @(posedge ACLK or negedge RESET_N) begin
      if (!RESET_N) begin
        sync_reg[gi] <= 1'b1;
      end else begin
        sync_reg[gi] <= (gi == 0) ? RXD : sync_reg[gi - 1];
      end
    end
  end

  assign rxs  = sync_reg[1];
  assign tick = (div_cnt == DIV_LAST);

  // Third vote sample is the live rxs, so the decision is made on that tick.
  assign maj       = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
  assign at_centre = tick && (sc == SC_S2);

  // Tick divider; cleared on the start edge so ticks line up with the frame.
  always_ff @(posedge ACLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
    end else if (clr_timing || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Sample counter. Wrapping modulo OVERSAMPLE puts the next vote exactly
  // one bit period after the current one, which is the re-phasing needed
  // after the start bit.
  always_ff @(posedge ACLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sc <= '0;
    end else if (clr_timing) begin
      sc <= '0;
    end else if (tick) begin
      sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
    end
  end

  // Capture the first two majority-vote samples around the bit centre.
  always_ff @(posedge ACLK or negedge RESET_N) begin
    if (!RESET_N) begin
      samp0 <= 1'b0;
      samp1 <= 1'b0;
    end else if (tick) begin
      if (sc == SC_S0) samp0 <= rxs;
      if (sc == SC_S1) samp1 <= rxs;
    end
  end

  // Bit counter and LSB-first shift register for the data bits.
  always_ff @(posedge ACLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (clr_timing) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 1'b1;
      shift   <= {maj, shift[7:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_next    = state;
    clr_timing    = 1'b0;
    shift_en      = 1'b0;
    deliver       = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          clr_timing = 1'b1;
        end
      end
      START: begin
        // A high majority means the low level was a glitch.
        if (at_centre) state_next = maj ? IDLE : DATA;
      end
      DATA: begin
        if (at_centre) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        // Leave at the stop-bit centre so the next start edge is not missed.
        if (at_centre) begin
          if (maj) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_next    = BREAK;
          end
        end
      end
      BREAK: begin
        // A line held low must go high again before a new frame can start.
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register, VALID/READ handshake, and the error pulses.
  always_ff @(posedge ACLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RX_DATA       <= '0;
      RX_DATA_VALID <= 1'b0;
      RX_FRAME_ERR  <= 1'b0;
      RX_OVERRUN    <= 1'b0;
    end else begin
      RX_FRAME_ERR <= frame_err_set;
      RX_OVERRUN   <= 1'b0;
      if (deliver) begin
        if (!RX_DATA_VALID || RX_DATA_READ) begin
          RX_DATA       <= shift;
          RX_DATA_VALID <= 1'b1;
        end else begin
          RX_OVERRUN <= 1'b1;
        end
      end else if (RX_DATA_READ) begin
        RX_DATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Testbench for uart_rx_sampler with 16 clocks per bit (DIV=1).
// Expected bytes are pushed to a queue when a frame is sent. They are popped
// and compared whenever the consumer reads a valid byte.
module tb_uart_rx_sampler;

  logic       ACLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       RXD = 1'b1;
  logic       RX_DATA_READ = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_DATA_VALID;
  logic       RX_FRAME_ERR;
  logic       RX_OVERRUN;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int ov_cyc = -1;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cnt = 0;
  bit valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_sampler #(
    .CLOCK_FREQ(1_843_200),
    .BAUD_RATE (115200),
    .OVERSAMPLE(16)
  ) dut (
    .ACLK         (ACLK),
    .RESET_N      (RESET_N),
    .RXD          (RXD),
    .RX_DATA_READ (RX_DATA_READ),
    .RX_DATA      (RX_DATA),
    .RX_DATA_VALID(RX_DATA_VALID),
    .RX_FRAME_ERR (RX_FRAME_ERR),
    .RX_OVERRUN   (RX_OVERRUN)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters, VALID-rise timing, and the scoreboard compare on each read.
  always @(negedge ACLK) begin
    if (RX_FRAME_ERR === 1'b1) fe_cnt++;
    if (RX_OVERRUN === 1'b1) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (RX_DATA_VALID === 1'b1 && !valid_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    valid_prev = (RX_DATA_VALID === 1'b1);
    if (RESET_N && RX_DATA_VALID === 1'b1 && RX_DATA_READ) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_rx_byte", 32'(RX_DATA), 32'(e));
        $display("read byte 0x%02h (expected 0x%02h) at cycle %0d", RX_DATA, e, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Drive an 8N1 frame (start, 8 data LSB-first, stop) for up to ncyc clocks.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ncyc);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    start_cyc = cyc;
    $display("send frame 0x%02h stop=%0b cycles=%0d at cycle %0d", d, stop, ncyc, cyc);
    for (int i = 0; i < ncyc; i++) begin
      RXD = f[i / 16];
      step();
    end
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (RX_DATA_VALID === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_read();
    RX_DATA_READ = 1'b1;
    step();
    RX_DATA_READ = 1'b0;
  endtask

  initial begin
    int lat;
    int fe0;
    int ov0;
    int rc0;
    bit ok;

    // Reset state
    repeat (3) step();
    check("rst_data", 32'(RX_DATA), 32'h00);
    check("rst_valid", 32'(RX_DATA_VALID), 32'd0);
    check("rst_frame_err", 32'(RX_FRAME_ERR), 32'd0);
    check("rst_overrun", 32'(RX_OVERRUN), 32'd0);
    RESET_N = 1'b1;
    repeat (5) step();

    // 1: single byte, latency window, READ clears VALID
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 160);
    check("t1_valid", 32'(RX_DATA_VALID), 32'd1);
    check("t1_data", 32'(RX_DATA), 32'h55);
    lat = rise_cyc - start_cyc;
    check("t1_latency_153_157", 32'(lat >= 153 && lat <= 157), 32'd1);
    $display("t1 latency %0d cycles", lat);
    do_read();
    check("t1_valid_after_read", 32'(RX_DATA_VALID), 32'd0);

    // 2: short glitch rejected, following frame intact
    rc0 = rise_cnt;
    RXD = 1'b0;
    repeat (4) step();
    RXD = 1'b1;
    repeat (40) step();
    check("t2_no_valid", 32'(rise_cnt), 32'(rc0));
    check("t2_no_frame_err", 32'(fe_cnt), 32'd0);
    check("t2_no_overrun", 32'(ov_cnt), 32'd0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 160);
    check("t2_valid", 32'(RX_DATA_VALID), 32'd1);
    do_read();

    // 3: stop bit low with line held low -> one framing error, no retrigger
    fe0 = fe_cnt;
    rc0 = rise_cnt;
    send_frame(8'hA3, 1'b0, 160);
    repeat (48) step();
    check("t3_one_frame_err", 32'(fe_cnt), 32'(fe0 + 1));
    check("t3_no_valid", 32'(RX_DATA_VALID), 32'd0);
    RXD = 1'b1;
    repeat (32) step();
    check("t3_no_retrigger", 32'(rise_cnt), 32'(rc0));
    check("t3_fe_still_one", 32'(fe_cnt), 32'(fe0 + 1));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 160);
    check("t3_resync_valid", 32'(RX_DATA_VALID), 32'd1);
    do_read();

    // 4: two bytes without READ -> overrun on the second, first byte kept
    ov0 = ov_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 160);
    send_frame(8'h34, 1'b1, 160);
    repeat (20) step();
    check("t4_valid", 32'(RX_DATA_VALID), 32'd1);
    check("t4_data_kept", 32'(RX_DATA), 32'h12);
    check("t4_one_overrun", 32'(ov_cnt), 32'(ov0 + 1));
    lat = ov_cyc - start_cyc;
    check("t4_overrun_at_stop_centre", 32'(lat >= 153 && lat <= 157), 32'd1);
    do_read();
    check("t4_valid_cleared", 32'(RX_DATA_VALID), 32'd0);

    // 5: back-to-back 0x00, 0xFF with a consumer reading one cycle after VALID
    ov0 = ov_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    fork
      begin
        send_frame(8'h00, 1'b1, 160);
        send_frame(8'hFF, 1'b1, 160);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_valid(400, ok);
          check("t5_valid_seen", 32'(ok), 32'd1);
          step();
          do_read();
        end
      end
    join
    repeat (4) step();
    check("t5_no_overrun", 32'(ov_cnt), 32'(ov0));
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // 5b: READ coincident with a new delivery -> new byte loaded, VALID stays 1
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 160);
    fork
      send_frame(8'h22, 1'b1, 160);
      begin
        repeat (156) step();
        RX_DATA_READ = 1'b1;
        step();
        RX_DATA_READ = 1'b0;
      end
    join
    check("t5b_valid", 32'(RX_DATA_VALID), 32'd1);
    check("t5b_new_data", 32'(RX_DATA), 32'h22);
    check("t5b_no_overrun", 32'(ov_cnt), 32'(ov0));
    do_read();
    check("t5b_valid_cleared", 32'(RX_DATA_VALID), 32'd0);

    // 6: reset during bit 4 of a frame while a byte is held
    send_frame(8'h77, 1'b1, 160);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h99, 1'b1, 16 * 5 + 8);
    RESET_N = 1'b0;
    RXD = 1'b1;
    #1;
    check("t6_rst_data", 32'(RX_DATA), 32'h00);
    check("t6_rst_valid", 32'(RX_DATA_VALID), 32'd0);
    check("t6_rst_frame_err", 32'(RX_FRAME_ERR), 32'd0);
    check("t6_rst_overrun", 32'(RX_OVERRUN), 32'd0);
    repeat (3) step();
    RESET_N = 1'b1;
    repeat (200) step();
    check("t6_no_valid_after_abort", 32'(RX_DATA_VALID), 32'd0);
    check("t6_no_fe_after_abort", 32'(fe_cnt), 32'(fe0));
    check("t6_no_ov_after_abort", 32'(ov_cnt), 32'(ov0));
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 160);
    check("t6_valid", 32'(RX_DATA_VALID), 32'd1);
    check("t6_data", 32'(RX_DATA), 32'hC3);
    do_read();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
